// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_redirect_ctrl_if : EX-side resolution inputs and fetch-side controls |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface branch_redirect_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             ex_valid;
   logic             ex_is_branch;
   logic             ex_is_jal;
   logic             ex_is_jalr;
   logic             cond_taken;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_rs1;
   logic             stall;
   logic             redirect_valid;
   logic [XLEN-1:0]  pc_target;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             misalign_err;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cond_taken,
      output ex_pc, ex_imm, ex_rs1, stall,
      input  redirect_valid, pc_target, flush_if_id, flush_id_ex, misalign_err,
      input  branch_cnt, taken_cnt
   );

   modport slave (
      input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, cond_taken,
      input  ex_pc, ex_imm, ex_rs1, stall,
      output redirect_valid, pc_target, flush_if_id, flush_id_ex, misalign_err,
      output branch_cnt, taken_cnt
   );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_redirect_ctrl : branch/JAL/JALR redirect, flush and branch stats     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module branch_redirect_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   branch_redirect_ctrl_if.slave  bus
);
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]  C_LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};

   state_t           state_q, state_d;
   logic             redirect_q, redirect_d;
   logic [XLEN-1:0]  target_q, target_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic             w_accept;
   logic             w_sel_jalr;
   logic             w_sel_jal;
   logic             w_sel_br;
   logic             w_resolve;
   logic [XLEN-1:0]  w_target;

   // JALR wins over JAL, JAL over a conditional branch, when decode sets several flags.
   always_comb begin
      w_accept   = (state_q == ST_IDLE) && bus.ex_valid && !bus.stall;
      w_sel_jalr = bus.ex_is_jalr;
      w_sel_jal  = !bus.ex_is_jalr && bus.ex_is_jal;
      w_sel_br   = !bus.ex_is_jalr && !bus.ex_is_jal && bus.ex_is_branch;
      w_target   = w_sel_jalr ? ((bus.ex_rs1 + bus.ex_imm) & C_LSB_CLR)
                              : (bus.ex_pc + bus.ex_imm);
      w_resolve  = w_accept && (w_sel_jalr || w_sel_jal || (w_sel_br && bus.cond_taken));
   end

   always_comb begin
      state_d      = state_q;
      redirect_d   = redirect_q;
      target_d     = target_q;
      misalign_d   = 1'b0;
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;

      case (state_q)
         ST_IDLE: begin
            redirect_d = 1'b0;
            misalign_d = w_resolve && w_target[1];
            if (w_resolve && !w_target[1]) begin
               state_d    = ST_REDIRECT;
               redirect_d = 1'b1;
               target_d   = w_target;
            end
         end
         ST_REDIRECT: begin
            // Whatever sits in EX now is wrong-path and is never evaluated.
            if (!bus.stall) begin
               state_d    = ST_IDLE;
               redirect_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            redirect_d = 1'b0;
         end
      endcase

      if (w_accept && w_sel_br) begin
         if (branch_cnt_q != C_CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + C_CNT_ONE;
         end
         if (bus.cond_taken && (taken_cnt_q != C_CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + C_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         redirect_q   <= 1'b0;
         target_q     <= '0;
         misalign_q   <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         redirect_q   <= redirect_d;
         target_q     <= target_d;
         misalign_q   <= misalign_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign bus.redirect_valid = redirect_q;
   assign bus.flush_if_id    = redirect_q;
   assign bus.flush_id_ex    = redirect_q;
   assign bus.pc_target      = target_q;
   assign bus.misalign_err   = misalign_q;
   assign bus.branch_cnt     = branch_cnt_q;
   assign bus.taken_cnt      = taken_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_redirect_ctrl : directed bench with reference model and checks    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_branch_redirect_ctrl;
   localparam int XLEN  = 32;
   localparam int CNT_W = 16;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: "busy" means a redirect is being presented to fetch.
   logic        m_busy;
   logic        m_mis;
   logic [31:0] m_target;
   int          m_bcnt;
   int          m_tcnt;
   logic [63:0] t_tgt;
   bit          t_is_br;
   bit          t_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_mis <= 1'b0; m_target <= '0; m_bcnt <= 0; m_tcnt <= 0;
      end else begin
         m_mis <= 1'b0;
         if (m_busy) begin
            if (!bus.stall) m_busy <= 1'b0;
         end else if (bus.ex_valid && !bus.stall) begin
            if (bus.ex_is_jalr)
               t_tgt = ((64'(bus.ex_rs1) + 64'(bus.ex_imm)) % 64'h1_0000_0000) / 2 * 2;
            else
               t_tgt = (64'(bus.ex_pc) + 64'(bus.ex_imm)) % 64'h1_0000_0000;
            t_is_br = !bus.ex_is_jalr && !bus.ex_is_jal && bus.ex_is_branch;
            t_res   = bus.ex_is_jalr || bus.ex_is_jal || (t_is_br && bus.cond_taken);
            if (t_is_br) begin
               if (m_bcnt < MAXC) m_bcnt <= m_bcnt + 1;
               if (bus.cond_taken && m_tcnt < MAXC) m_tcnt <= m_tcnt + 1;
            end
            if (t_res) begin
               if ((t_tgt % 4) >= 2) m_mis <= 1'b1;
               else begin
                  m_busy   <= 1'b1;
                  m_target <= t_tgt[31:0];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("redirect_valid", 64'(bus.redirect_valid), 64'(m_busy));
      chk("flush_if_id",    64'(bus.flush_if_id),    64'(m_busy));
      chk("flush_id_ex",    64'(bus.flush_id_ex),    64'(m_busy));
      chk("misalign_err",   64'(bus.misalign_err),   64'(m_mis));
      chk("branch_cnt",     64'(bus.branch_cnt),     64'(m_bcnt));
      chk("taken_cnt",      64'(bus.taken_cnt),      64'(m_tcnt));
      if (m_busy) chk("pc_target", 64'(bus.pc_target), 64'(m_target));
   end

   task automatic set_ex(input logic br, input logic jal, input logic jalr, input logic ct,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
      bus.ex_valid     = 1'b1;
      bus.ex_is_branch = br;
      bus.ex_is_jal    = jal;
      bus.ex_is_jalr   = jalr;
      bus.cond_taken   = ct;
      bus.ex_pc        = pc;
      bus.ex_imm       = imm;
      bus.ex_rs1       = rs1;
   endtask

   task automatic clr_ex();
      bus.ex_valid     = 1'b0;
      bus.ex_is_branch = 1'b0;
      bus.ex_is_jal    = 1'b0;
      bus.ex_is_jalr   = 1'b0;
      bus.cond_taken   = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      clr_ex();
      bus.stall = 1'b0;
      bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0;
      repeat (3) tick();
      chk("lit_rst_redirect", 64'(bus.redirect_valid), 64'd0);
      chk("lit_rst_target",   64'(bus.pc_target),      64'd0);
      chk("lit_rst_bcnt",     64'(bus.branch_cnt),     64'd0);
      rst_n = 1'b1;
      tick();

      // BEQ taken, wrong-path JAL left in EX during the redirect cycle
      set_ex(1, 0, 0, 1, 32'h100, 32'h20, 32'h0);
      tick();
      set_ex(0, 1, 0, 0, 32'h500, 32'h0, 32'h0);
      chk("lit_beq_redirect", 64'(bus.redirect_valid), 64'd1);
      chk("lit_beq_target",   64'(bus.pc_target),      64'h120);
      chk("lit_beq_flush",    64'({bus.flush_if_id, bus.flush_id_ex}), 64'd3);
      chk("lit_beq_cnts",     64'({bus.branch_cnt, bus.taken_cnt}), 64'h0001_0001);
      tick();
      clr_ex();
      chk("lit_beq_done", 64'(bus.redirect_valid), 64'd0);

      // BNE not taken
      set_ex(1, 0, 0, 0, 32'h104, 32'h40, 32'h0);
      tick();
      clr_ex();
      chk("lit_bne_redirect", 64'(bus.redirect_valid), 64'd0);
      chk("lit_bne_cnts",     64'({bus.branch_cnt, bus.taken_cnt}), 64'h0002_0001);

      // JALR misaligned then aligned
      set_ex(0, 0, 1, 0, 32'h0, 32'h4, 32'h2003);
      tick();
      clr_ex();
      chk("lit_jalr_mis", 64'({bus.misalign_err, bus.redirect_valid}), 64'b10);
      tick();
      chk("lit_jalr_mis_pulse", 64'(bus.misalign_err), 64'd0);
      set_ex(0, 0, 1, 0, 32'h0, 32'h3, 32'h2001);
      tick();
      clr_ex();
      chk("lit_jalr_target", 64'(bus.pc_target), 64'h2004);
      chk("lit_jalr_cnts",   64'({bus.branch_cnt, bus.taken_cnt}), 64'h0002_0001);
      tick();

      // Stall for 3 cycles during REDIRECT
      set_ex(1, 0, 0, 1, 32'h300, 32'h40, 32'h0);
      tick();
      clr_ex();
      bus.stall = 1'b1;
      chk("lit_stall_target", 64'(bus.pc_target), 64'h340);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lit_stall_hold", 64'(bus.redirect_valid), 64'd1);
      end
      bus.stall = 1'b0;
      tick();
      chk("lit_stall_release", 64'(bus.redirect_valid), 64'd0);
      chk("lit_stall_cnts",    64'({bus.branch_cnt, bus.taken_cnt}), 64'h0003_0002);

      // Stall in IDLE with a branch frozen in EX
      set_ex(1, 0, 0, 0, 32'h400, 32'h8, 32'h0);
      bus.stall = 1'b1;
      tick();
      tick();
      chk("lit_idle_stall_nocnt", 64'(bus.branch_cnt), 64'd3);
      bus.stall = 1'b0;
      tick();
      clr_ex();
      chk("lit_idle_stall_cnt", 64'(bus.branch_cnt), 64'd4);

      // Address wrap on JAL
      set_ex(0, 1, 0, 0, 32'hFFFF_FFF8, 32'h10, 32'h0);
      tick();
      clr_ex();
      chk("lit_wrap_target", 64'(bus.pc_target), 64'h8);
      tick();

      // All type flags set: JALR takes priority and is not counted
      set_ex(1, 1, 1, 1, 32'h0, 32'h10, 32'h1000);
      tick();
      clr_ex();
      chk("lit_prio_target", 64'(bus.pc_target), 64'h1010);
      chk("lit_prio_cnts",   64'({bus.branch_cnt, bus.taken_cnt}), 64'h0004_0002);
      tick();

      // Back-to-back: second resolve waits until the redirect finishes
      set_ex(1, 0, 0, 1, 32'h600, 32'h10, 32'h0);
      tick();
      set_ex(0, 1, 0, 0, 32'h800, 32'h8, 32'h0);
      chk("lit_b2b_first", 64'(bus.pc_target), 64'h610);
      tick();
      chk("lit_b2b_gap", 64'(bus.redirect_valid), 64'd0);
      tick();
      clr_ex();
      chk("lit_b2b_second", 64'({bus.redirect_valid, bus.pc_target}), {31'd0, 1'b1, 32'h808});
      chk("lit_b2b_cnts",   64'({bus.branch_cnt, bus.taken_cnt}), 64'h0005_0003);
      tick();

      // Reset asserted in the middle of a redirect cycle
      set_ex(1, 0, 0, 1, 32'h40, 32'h4, 32'h0);
      tick();
      clr_ex();
      chk("lit_rstmid_before", 64'(bus.pc_target), 64'h44);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_rstmid_out", 64'({bus.redirect_valid, bus.flush_if_id, bus.flush_id_ex}), 64'd0);
      chk("lit_rstmid_cnts", 64'({bus.branch_cnt, bus.taken_cnt}), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("lit_rstmid_after", 64'({bus.redirect_valid, bus.misalign_err}), 64'd0);

      // Counter saturation, then a taken-but-misaligned branch
      set_ex(1, 0, 0, 0, 32'h0, 32'h8, 32'h0);
      repeat (MAXC + 5) tick();
      chk("lit_sat_bcnt", 64'(bus.branch_cnt), 64'hFFFF);
      chk("lit_sat_tcnt", 64'(bus.taken_cnt),  64'h0);
      set_ex(1, 0, 0, 1, 32'h0, 32'h2, 32'h0);
      tick();
      clr_ex();
      chk("lit_sat_mis",  64'({bus.misalign_err, bus.redirect_valid}), 64'b10);
      chk("lit_sat_cnts", 64'({bus.branch_cnt, bus.taken_cnt}), 64'hFFFF_0001);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
